mdu_multicycle: RTL and testbench
=================================

Name: mdu_multicycle

Overview:
- Parametrised multicycle multiply/divide unit (HI/LO) for the multicycle MIPS core.
- Sits beside the ALU. The control FSM issues a start pulse and stalls on busy. Results land in HI/LO, which the write-back mux reads; the core can also write them directly.
- Generalises the fixed 32-bit single-cycle ALU path to a configurable-width, iterative shift-add / restoring-divide engine with a handshake.

Parameters:
- WIDTH, 32, operand width and HI/LO width; legal range 4..64.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0. All internal counters and accumulators are cleared. An operation in flight is aborted with no partial HI/LO update.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On a clock edge with start=1, latch op, |a|, |b| and the sign flags. Magnitudes are taken only for signed ops; unsigned ops pass a and b through.
  - Counter=0, busy=1, go to CALC.
- CALC:
  - One iteration per cycle, exactly WIDTH cycles.
  - MUL: shift-add on a 2*WIDTH-bit product.
  - DIV: restoring division producing a WIDTH-bit quotient and remainder.
  - After the WIDTH-th iteration, go to FIX.
- FIX, one cycle:
  - Signed MULT: negate the product if sign(a)^sign(b).
  - Signed DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a). Quotient truncates toward zero.
  - Write hi/lo on the exit edge. MUL: hi=product[2W-1:W], lo=product[W-1:0]. DIV: hi=remainder, lo=quotient.
  - On the same edge: done=1 for one cycle, busy=0, return to IDLE.
- Latency: with start sampled at edge 0, the results and done appear after edge WIDTH+1. busy is high for WIDTH+1 cycles.
- A new start is accepted in the cycle done is high (busy=0).
- start while busy=1: ignored. It is neither queued nor allowed to corrupt the operation.
- Divide by zero (no macro): runs the full latency. Result is hi=a and lo=all ones for both DIV and DIVU; sign fix is bypassed for this case.
- Signed overflow, DIV of minimum value by -1: lo=minimum value, hi=0. No flag.
- hi_we/lo_we:
  - Honoured only when busy=0 and not in the FIX exit cycle; ignored while busy=1.
  - hi_we and lo_we together write the same wdata to both registers.
  - If hi_we/lo_we and start are asserted on the same edge, the write takes effect and the operation also starts. The operation's result later overwrites HI/LO.
- hi/lo hold their value between operations and writes.

Optional Feature:
- Macro: MDU_DIV0_FAST_EN.
- Defined:
  - Adds output port div0 (1 bit, reset 0).
  - DIV/DIVU with b=0 skips CALC, going IDLE -> FIX. Results (hi=a, lo=all ones) and done appear after edge 1.
  - div0=1 for the same cycle as done, 0 otherwise.
- Undefined:
  - No div0 port.
  - Divide by zero takes the normal WIDTH+1 latency with the same hi/lo values.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles: done pulse, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0:
  - Without macro: done after 33 cycles, hi=0x1234, lo=0xFFFFFFFF.
  - With MDU_DIV0_FAST_EN: done and div0 after 1 cycle, same values.
- Second start mid-operation (cycle 10 of MULTU 5*6), plus hi_we=1 wdata=0xAAAA at cycle 12 -> both ignored; result hi=0, lo=30. hi_we after done -> hi=0xAAAA.
- Assert rst at cycle 15 of DIVU 100/7 -> hi=lo=0, busy=0 immediately; fresh DIVU 100/7 after release -> lo=14, hi=2.

Source files
------------

// File: rtl/mdu_multicycle.sv
// Multicycle multiply/divide unit with HI/LO registers (shift-add / restoring divide).
// Optional fast divide-by-zero path and div0 flag: define MDU_DIV0_FAST_EN.
module mdu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FAST_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            dz_q, dz_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  logic            in_sa, in_sb;
  logic [WIDTH-1:0] in_ma, in_mb;
  logic [WIDTH:0]  msum;
  logic [WIDTH:0]  dtop;
  logic [WIDTH:0]  ddiff;
  logic [W2-1:0]   prod;
  logic [WIDTH-1:0] quo, rem;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand conditioning: magnitudes and signs for signed ops only.
  always_comb begin
    in_sa = ~op[0] & a[WIDTH-1];
    in_sb = ~op[0] & b[WIDTH-1];
    in_ma = in_sa ? -a : a;
    in_mb = in_sb ? -b : b;
  end

  // Datapath step terms for one multiply or divide iteration.
  always_comb begin
    msum  = {1'b0, acc_q[W2-1:WIDTH]}
          + (acc_q[0] ? {1'b0, ma_q} : '0);
    dtop  = acc_q[W2-1:WIDTH-1];
    ddiff = dtop - {1'b0, mb_q};
  end

  // Sign fix-up of the finished product, quotient and remainder.
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[W2-1:WIDTH];
    if (sa_q ^ sb_q) quo = -quo;
    if (sa_q)        rem = -rem;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d  = op;
          sa_d  = in_sa;
          sb_d  = in_sb;
          ma_d  = in_ma;
          mb_d  = in_mb;
          dz_d  = op[1] & (b == '0);
          cnt_d = '0;
          acc_d = op[1] ? {{WIDTH{1'b0}}, in_ma}
                        : {{WIDTH{1'b0}}, in_mb};
          state_d = S_CALC;
`ifdef MDU_DIV0_FAST_EN
          if (op[1] && (b == '0)) state_d = S_FIX;
`endif
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          if (!ddiff[WIDTH])
            acc_d = {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {dtop[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = sa_q ? -ma_q : ma_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MDU_DIV0_FAST_EN
  logic div0_q;

  // Divide-by-zero flag, pulsed alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div0_q <= 1'b0;
    else     div0_q <= (state_q == S_FIX) & op_q[1] & dz_q;
  end

  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: directed cases plus random ops vs. arithmetic model.
// Covers latency, busy length, ignored starts/writes, reset abort.
module tb_mdu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MDU_DIV0_FAST_EN
  logic         div0;
`endif

  int ntests = 0;
  int nfail  = 0;

  mdu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MDU_DIV0_FAST_EN
    ,
    .div0  (div0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural operands.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output logic [W-1:0] eh,
                       output logic [W-1:0] el);
    longint sp, sq, sr;
    logic [63:0] up;
    if (o[1] && y == 0) begin
      eh = x;
      el = '1;
    end else begin
      case (o)
        2'd0: begin
          sp = longint'($signed(x)) * longint'($signed(y));
          eh = sp[63:32]; el = sp[31:0];
        end
        2'd1: begin
          up = {32'd0, x} * {32'd0, y};
          eh = up[63:32]; el = up[31:0];
        end
        2'd2: begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          eh = sr[31:0]; el = sq[31:0];
        end
        default: begin
          eh = x % y; el = x / y;
        end
      endcase
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
`ifdef MDU_DIV0_FAST_EN
    if (o[1] && y == 0) return 1;
`endif
    return W + 1;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run(input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input bit wr,
                     input logic [W-1:0] wd, output int lat,
                     output int bcnt, output logic [W-1:0] h0,
                     output logic [W-1:0] l0);
    start = 1'b1; op = o; a = x; b = y;
    hi_we = wr; lo_we = wr; wdata = wd;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    h0 = hi; l0 = lo;
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    int lat, bc;
    logic [W-1:0] h0, l0, eh, el;
    model(o, x, y, eh, el);
    run(o, x, y, 1'b0, '0, lat, bc, h0, l0);
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat(o, y)));
    check({tag, ".hi"}, 64'(hi), 64'(eh));
    check({tag, ".lo"}, 64'(lo), 64'(el));
`ifdef MDU_DIV0_FAST_EN
    check({tag, ".div0"}, 64'(div0), 64'(o[1] && y == 0));
`endif
  endtask

  initial begin
    int lat, bc;
    logic [W-1:0] h0, l0, eh, el, x, y;
    logic [1:0] o;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.hi", 64'(hi), 64'(0));
    check("rst.lo", 64'(lo), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max*max with busy length
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, lat, bc, h0, l0);
    check("multu.lat", 64'(lat), 64'(33));
    check("multu.busy", 64'(bc), 64'(33));
    check("multu.done", 64'(done), 64'(1));
    check("multu.hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu.lo", 64'(lo), 64'h0000_0001);
    @(negedge clk);
    check("done.pulse", 64'(done), 64'(0));

    op_check("mult", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult.hi.k", 64'(hi), 64'hFFFF_FFFF);
    check("mult.lo.k", 64'(lo), 64'hFFFF_FFEB);
    op_check("div", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div.lo.k", 64'(lo), 64'hFFFF_FFFD);
    check("div.hi.k", 64'(hi), 64'hFFFF_FFFF);
    op_check("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf.lo.k", 64'(lo), 64'h8000_0000);
    check("divovf.hi.k", 64'(hi), 64'h0);
    op_check("divu0", 2'd3, 32'h0000_1234, 32'd0);
    check("divu0.hi.k", 64'(hi), 64'h1234);
    check("divu0.lo.k", 64'(lo), 64'hFFFF_FFFF);
    op_check("div0s", 2'd2, 32'hFFFF_FF00, 32'd0);
    @(negedge clk);

    // MULTU 5*6 with stray start at 10 and hi_we at 12
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat == 10); op = 2'd3; a = 32'd1; b = 32'd1;
      hi_we = (lat == 12); wdata = 32'hAAAA;
      @(negedge clk);
      lat++;
    end
    start = 1'b0; hi_we = 1'b0;
    check("ign.lat", 64'(lat), 64'(33));
    check("ign.hi", 64'(hi), 64'h0);
    check("ign.lo", 64'(lo), 64'd30);
    @(negedge clk);
    check("ign.busy", 64'(busy), 64'(0));
    hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi.hi", 64'(hi), 64'hAAAA);
    check("mthi.lo", 64'(lo), 64'd30);
    lo_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h5555);

    // Write together with start: write now, result later
    run(2'd1, 32'd9, 32'd9, 1'b1, 32'h1357, lat, bc, h0, l0);
    check("wrst.hi0", 64'(h0), 64'h1357);
    check("wrst.lo0", 64'(l0), 64'h1357);
    check("wrst.lo", 64'(lo), 64'd81);
    check("wrst.hi", 64'(hi), 64'd0);

    // Reset abort mid DIVU 100/7
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.hi", 64'(hi), 64'h0);
    check("abort.lo", 64'(lo), 64'h0);
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op_check("divu7", 2'd3, 32'd100, 32'd7);
    check("divu7.lo.k", 64'(lo), 64'd14);
    check("divu7.hi.k", 64'(hi), 64'd2);

    // Random back-to-back ops (start in the done cycle)
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'($urandom_range(1, 20));
        2: x = 32'h8000_0000;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, x, y, eh, el);
      run(o, x, y, 1'b0, '0, lat, bc, h0, l0);
      check($sformatf("rnd%0d.lat", i), 64'(lat), 64'(exp_lat(o, y)));
      check($sformatf("rnd%0d.busy", i), 64'(bc), 64'(exp_lat(o, y)));
      check($sformatf("rnd%0d.hi", i), 64'(hi), 64'(eh));
      check($sformatf("rnd%0d.lo", i), 64'(lo), 64'(el));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
